uart_word_packer: RTL
=====================

# uart_word_packer

Consumes the per-byte completion strobe and data of the UART receiver and packs consecutive bytes, little-endian, into 32-bit words tagged with a running word address. Completed words queue in a small FIFO and leave through a valid/ready port to the program-load / memory-write logic. An inter-byte timeout discards stale partial words so a broken transfer cannot misalign later ones.

## Interface
Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz
- TIMEOUT_US, 1000, inter-byte timeout in microseconds; TIMEOUT_CYC = (CLK_FREQ/1_000_000)*TIMEOUT_US
- ADDR_W, 14, word address width
- FIFO_DEPTH, 4, output queue entries, power of two, ≥2

Ports (one clock; reset is synchronous and active-high):
- sys_clk  in  1  system clock, all logic on rising edge
- sys_rst  in  1  synchronous active-high reset
- byte_done  in  1  receiver completion level; may stay high many cycles per byte
- byte_data  in  8  received byte, valid while byte_done=1
- clear  in  1  synchronous restart: drop partial word, flush FIFO, address to 0, clear flags
- word_valid  out  1  FIFO head valid
- word_ready  in  1  consumer accepts head
- word_data  out  32  packed word, first byte in [7:0]
- word_addr  out  ADDR_W  word index of word_data
- busy  out  1  partial word held (byte_idx≠0)
- overflow  out  1  sticky: completed word dropped, FIFO full
- timeout_err  out  1  sticky: partial word discarded by timeout

## Operation
- Edge detect: register done_q <= byte_done; byte accepted in the cycle byte_done=1 && done_q=0; byte_data sampled that cycle. done_q resets to 1, so a level held across reset is not a byte.
- Packing: 2-bit byte_idx; accepted byte written to lane byte_idx (bits 8*idx+7:8*idx); idx increments, wraps 3→0.
- Word complete on acceptance at idx=3: {addr_cnt, assembled word} pushed; addr_cnt increments modulo 2^ADDR_W whether or not the push succeeded.
- Push when FIFO full and no pop that cycle: word dropped, overflow<=1. Full with simultaneous pop: push succeeds.
- Output: word_valid = FIFO not empty; word_data/word_addr show head; pop on word_valid && word_ready. Head stable while word_valid && !word_ready.
- Timeout: counter cleared on every accepted byte, counts while byte_idx≠0; on reaching TIMEOUT_CYC-1, byte_idx<=0, partial lanes discarded, timeout_err<=1, addr_cnt unchanged. Byte accepted in the same cycle as expiry wins: counter clears, no timeout.
- Priority: sys_rst > clear > normal operation. clear does not reset done_q.
- Sticky flags cleared only by sys_rst or clear.

## Timing
- Reset values: word_valid=0, word_data=0, word_addr=0, busy=0, overflow=0, timeout_err=0; byte_idx=0, addr_cnt=0, FIFO empty, timeout counter 0.
- Fourth byte accepted at rising edge N → word_valid=1 after edge N+1 if FIFO was empty (one-cycle latency). busy falls after edge N.
- Pop at edge M → next head (or word_valid=0) visible after edge M.
- Back-to-back full-throughput: one push and one pop per cycle sustained.
- overflow/timeout_err set after the edge of the causing event.

## Structure
- Shared package uart_pkg: BYTES_PER_WORD=4, lane index width, timeout-cycle calculation function; receiver and packer both import it.
- One sub-module: word_fifo, synchronous FIFO, width ADDR_W+32, depth FIFO_DEPTH, push/pop/full/empty, same sys_clk/sys_rst.
- Packer top holds edge detect, lane assembly, address counter, timeout counter, flags.

## Test plan
- Bytes 0x11,0x22,0x33,0x44, byte_done held 3 cycles each → one word 0x44332211 at word_addr 0, word_valid one cycle after 4th acceptance; busy high between bytes 1 and 4.
- byte_done held high across sys_rst release, then low, then 4 bytes 0xAA..0xDD → exactly one word 0xDDCCBBAA, no extra byte.
- word_ready=0, FIFO_DEPTH=4, send 5 words → entries addr 0..3 retained, overflow=1; next word after draining gets addr 5.
- Send 2 bytes, idle TIMEOUT_CYC cycles → timeout_err=1, busy=0; then 4 bytes 0x01..0x04 → word 0x04030201 at addr 0.
- Byte accepted exactly in expiry cycle → no timeout_err, packing continues.
- clear pulse with 2 FIFO entries and 3 bytes partial, flags set → word_valid=0, busy=0, flags 0, next word at addr 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: word geometry and timeout sizing.
package uart_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    function automatic int timeout_cycles(input int clk_freq, input int us);
        return (clk_freq / 1_000_000) * us;
    endfunction

endpackage

// File: rtl/uart_word_packer_fifo.sv
// Synchronous FIFO holding completed {address, word} entries.
module word_fifo #(
    parameter int W     = 46,
    parameter int DEPTH = 4
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_q;
    logic [AW:0]  rd_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= wdata_i;
                wr_q                <= wr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_word_packer.sv
// Packs UART receive bytes little-endian into addressed 32-bit words.
module uart_word_packer
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int TIMEOUT_US = 1000,
    parameter int ADDR_W     = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              byte_done,
    input  logic [7:0]        byte_data,
    input  logic              clear,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [31:0]       word_data,
    output logic [ADDR_W-1:0] word_addr,
    output logic              busy,
    output logic              overflow,
    output logic              timeout_err
);

    localparam int TIMEOUT_CYC = timeout_cycles(CLK_FREQ, TIMEOUT_US);
    localparam int TMR_W       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int FW          = ADDR_W + 32;
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BYTES_PER_WORD - 1);

    logic              done_q;
    logic [LANE_W-1:0] idx_q,   idx_d;
    logic [23:0]       lanes_q, lanes_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [TMR_W-1:0]  tmr_q,   tmr_d;
    logic              push_q,  push_d;
    logic [FW-1:0]     pdata_q, pdata_d;
    logic              ovf_q,   ovf_d;
    logic              to_q,    to_d;

    logic          accept;
    logic          pop;
    logic          full;
    logic          empty;
    logic [FW-1:0] head;

    assign accept = byte_done && !done_q;
    assign pop    = word_valid && word_ready;

    always_comb begin
        idx_d   = idx_q;
        lanes_d = lanes_q;
        addr_d  = addr_q;
        tmr_d   = tmr_q;
        push_d  = 1'b0;
        pdata_d = pdata_q;
        ovf_d   = ovf_q;
        to_d    = to_q;
        if (clear) begin
            idx_d   = '0;
            lanes_d = '0;
            addr_d  = '0;
            tmr_d   = '0;
            ovf_d   = 1'b0;
            to_d    = 1'b0;
        end else begin
            if (push_q && full && !pop) begin
                ovf_d = 1'b1;
            end
            if (accept) begin
                tmr_d = '0;
                idx_d = idx_q + LANE_W'(1);
                unique case (idx_q)
                    2'd0:    lanes_d[7:0]   = byte_data;
                    2'd1:    lanes_d[15:8]  = byte_data;
                    2'd2:    lanes_d[23:16] = byte_data;
                    default: lanes_d        = lanes_q;
                endcase
                // Address advances even if the FIFO later drops the word.
                if (idx_q == LANE_LAST) begin
                    push_d  = 1'b1;
                    pdata_d = {addr_q, byte_data, lanes_q};
                    addr_d  = addr_q + ADDR_W'(1);
                    lanes_d = '0;
                end
            end else if (idx_q != '0) begin
                if (tmr_q == TMR_LAST) begin
                    idx_d   = '0;
                    lanes_d = '0;
                    tmr_d   = '0;
                    to_d    = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            done_q  <= 1'b1;
            idx_q   <= '0;
            lanes_q <= '0;
            addr_q  <= '0;
            tmr_q   <= '0;
            push_q  <= 1'b0;
            pdata_q <= '0;
            ovf_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            done_q  <= byte_done;
            idx_q   <= idx_d;
            lanes_q <= lanes_d;
            addr_q  <= addr_d;
            tmr_q   <= tmr_d;
            push_q  <= push_d;
            pdata_q <= pdata_d;
            ovf_q   <= ovf_d;
            to_q    <= to_d;
        end
    end

    word_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .flush_i (clear),
        .push_i  (push_q),
        .wdata_i (pdata_q),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign word_valid  = !empty;
    assign word_addr   = head[FW-1:32];
    assign word_data   = head[31:0];
    assign busy        = (idx_q != '0);
    assign overflow    = ovf_q;
    assign timeout_err = to_q;

endmodule
